// File: rtl/mac_pkg.sv
// Shared types and constants for the mac FIR sequencing controller.
package mac_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    localparam int SAMPLE_W    = 8;
    localparam int COEF_W      = 16;
    localparam int ACC_W       = 48;
    localparam int DEF_W_L     = 5;
    localparam int DEF_MAC_LAT = 7;

endpackage

// File: rtl/mac_ctrl_valid_pipe.sv
// Fixed-depth 1-bit shift register that tracks which pipeline slots carry real data.
module valid_pipe #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] vld_p;

    generate
        if (DEPTH == 1) begin : g_single
            // Single stage: plain flop
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_p <= '0;
                else     vld_p <= din;
            end
        end else begin : g_chain
            // Shift the valid flag one stage per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_p <= '0;
                else     vld_p <= {vld_p[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = vld_p[DEPTH-1];

endmodule

// File: rtl/mac_ctrl.sv
// Sequencing controller for the mac systolic FIR: sample handshake, double-buffered
// coefficient bank swapped only after the tap chain is flushed, and output valid tracking.
module mac_ctrl
    import mac_pkg::*;
#(
    parameter int W_L     = DEF_W_L,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_we,
    input  logic [7:0]                 coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       coef_commit,
    output logic                       coef_err,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [SAMPLE_W-1:0]        s_data,
    output logic [SAMPLE_W-1:0]        component,
    output logic [W_L*COEF_W-1:0]      coeffs,
    input  logic signed [ACC_W-1:0]    p,
    output logic                       m_valid,
    output logic signed [ACC_W-1:0]    m_data,
    output logic                       busy
);

    localparam int          CNT_W   = $clog2(MAC_LAT + 1);
    localparam int          AW      = (W_L > 1) ? $clog2(W_L) : 1;
    localparam logic [7:0]  W_L_B   = 8'(W_L);

    state_t                    state;
    logic [CNT_W-1:0]          drain_cnt;
    logic                      pending;
    logic signed [COEF_W-1:0]  shadow [W_L];
    logic                      accept;
    logic                      addr_ok;

    assign accept  = s_valid & s_ready;
    assign addr_ok = coef_addr < W_L_B;

    // Run/drain/swap sequencer with registered handshake and busy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            pending   <= 1'b0;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            coeffs    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (coef_commit || pending) begin
                        state     <= DRAIN;
                        drain_cnt <= CNT_W'(MAC_LAT - 1);
                        pending   <= 1'b0;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Copy happens on the edge entering SWAP, so a same-edge
                    // shadow write is not seen by the active bank.
                    if (drain_cnt == '0) begin
                        state <= SWAP;
                        for (int k = 0; k < W_L; k++) begin
                            coeffs[k*COEF_W +: COEF_W] <= shadow[k];
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                SWAP: begin
                    state   <= RUN;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                    if (coef_commit) pending <= 1'b1;
                end
                default: begin
                    state   <= RUN;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Software writes to the shadow bank, allowed in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < W_L; k++) shadow[k] <= '0;
        end else if (coef_we && addr_ok) begin
            shadow[coef_addr[AW-1:0]] <= coef_data;
        end
    end

    // One-cycle error pulse for an out-of-range shadow write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coef_err <= 1'b0;
        else     coef_err <= coef_we && !addr_ok;
    end

    // Feed the accepted sample, or a zero on idle/drain cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         component <= '0;
        else if (accept) component <= s_data;
        else             component <= '0;
    end

    valid_pipe #(
        .DEPTH (MAC_LAT)
    ) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (accept),
        .dout (m_valid)
    );

    assign m_data = p;

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencing controller for the `mac` systolic FIR datapath (W_L chained `dsp16x8` taps). It accepts 8-bit samples over a valid/ready handshake and drives `component` each cycle. It also holds a double-buffered coefficient bank (shadow written by software, active driving `coeffs`) and swaps the banks only after the tap chain has drained. It tracks in-flight samples so `m_valid` marks exactly the `p` values that belong to accepted samples. Sits beside `mac` in the filter top level; it does not instantiate `mac`.

## Interface
Parameters:
- `W_L`, 5: tap count; must match `mac`.
- `MAC_LAT`, 7: cycles from the accepting edge of a sample to `p` carrying its result; must match the `mac` pipeline depth.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `coef_we`  in  1  write strobe to shadow bank.
- `coef_addr`  in  8  tap index 0..W_L-1.
- `coef_data`  in  16  signed coefficient.
- `coef_commit`  in  1  request shadow→active swap.
- `coef_err`  out  1  one-cycle pulse: write with `coef_addr >= W_L`.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample ready.
- `s_data`  in  8  sample.
- `component`  out  8  to `mac.component`.
- `coeffs`  out  W_L*16  to `mac.coeffs`; tap k at [16k+15:16k].
- `p`  in  48  from `mac.p`.
- `m_valid`  out  1  `m_data` holds a real result.
- `m_data`  out  48  equals `p` (pass-through).
- `busy`  out  1  high when state ≠ RUN.

## Operation
- Reset values: state RUN, `s_ready`=1, `component`=0, `coeffs`=0, shadow bank=0, valid pipe=0, `m_valid`=0, `coef_err`=0, `busy`=0, commit-pending=0.
- Accept = `s_valid & s_ready` at an edge. On accept, `component` ← `s_data` and a 1 enters the valid pipe. Otherwise `component` ← 0 and a 0 enters. Idle cycles are zero samples, which is correct FIR semantics because `mac` has no enable.
- Shadow write: `coef_we` with addr < W_L writes shadow[addr] in any state. An out-of-range write changes nothing and pulses `coef_err` the next cycle.
- FSM:
  - RUN: `s_ready`=1. `coef_commit` (or a pending commit) → DRAIN; the drain counter loads MAC_LAT-1.
  - DRAIN: `s_ready`=0, zeros fed. The counter decrements; at 0 → SWAP.
  - SWAP: active ← shadow (whole bank, one edge) → RUN.
- A commit in DRAIN is merged (no effect). A commit in SWAP sets the pending flag, so RUN re-enters DRAIN immediately.
- Commit and accept at the same RUN edge: the sample is accepted and the FSM goes to DRAIN.
- A write and the SWAP in the same cycle: active takes the pre-write shadow value; shadow takes the new value.
- Filter history is lost across a swap, because the chain is flushed with zeros.
- `rst` asserted mid-DRAIN or mid-SWAP: immediate return to reset values; the pending commit is discarded.

## Timing
- Sample latency: accept at edge t → `m_valid`=1 during cycle t+MAC_LAT (valid pipe depth MAC_LAT). `m_data` is not registered.
- `m_valid` is high for exactly one cycle per accepted sample. There is no output backpressure.
- Commit seen at edge t in RUN: `s_ready` is low for cycles t+1 .. t+MAC_LAT+1 (MAC_LAT DRAIN cycles plus 1 SWAP cycle). The new `coeffs` are visible from cycle t+MAC_LAT+1, and `s_ready`=1 again at t+MAC_LAT+2.
- `coef_err`: registered, one cycle after the offending write.

## Structure
- Package `mac_pkg` holds:
  - state enum (RUN, DRAIN, SWAP);
  - `SAMPLE_W`=8, `COEF_W`=16, `ACC_W`=48;
  - default `W_L`, `MAC_LAT`.
- Sub-module `valid_pipe`: a MAC_LAT-deep 1-bit shift register with async reset. It is reusable for other DSP chains.

## Test plan
- Reset and idle: pulse `rst` asynchronously mid-cycle → all outputs at reset values at once; `s_ready`=1, `busy`=0, `m_valid` never asserts while `s_valid`=0.
- Load and swap: write shadow[0..4]=1,2,3,4,5, then commit → `busy` high for 8 cycles and `s_ready` low for 8 cycles. Then `coeffs`=0x0005_0004_0003_0002_0001 (MSB tap 4).
- Impulse: after the swap, accept sample 1, then hold `s_valid`=0 → `m_valid` high for exactly one cycle, 7 cycles after the accept, with `m_data`=`p` at that cycle.
- Commit during streaming: `s_valid`=1 continuously, commit with sample 0x10 → 0x10 accepted, and its `m_valid` still appears. No further accept for 8 cycles; streaming resumes with the new coefficients.
- Bad address: `coef_we` with `coef_addr`=5 and data 0x7FFF → `coef_err` pulses one cycle. After a commit, `coeffs` are unchanged.
- Reset mid-drain: commit, then assert `rst` on the 3rd DRAIN cycle → state RUN and `coeffs`=0. The shadow is cleared and no swap occurs after release.
